// File: rtl/store_merge_if.sv
// Store-merge controller bus: store request, memory port and status.
// start is a one-cycle request taken only while busy=0; there is no ready, a start seen while busy is dropped.
interface store_merge_if;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [2:0]  fsm_state;

    modport master (
        output start, size, addr, wdata, mem_rdata,
        input  mem_addr, mem_wdata, mem_wr, busy, done, misalign, fsm_state
    );

    modport slave (
        input  start, size, addr, wdata, mem_rdata,
        output mem_addr, mem_wdata, mem_wr, busy, done, misalign, fsm_state
    );
endinterface

// File: rtl/store_merge_ctrl.sv
// Sub-word store merge: read-modify-write for SB/SH, direct write for SW.
// Optional alignment rejection when STORE_MISALIGN_CHECK_EN is defined.
module store_merge_ctrl (
    input logic           clk,
    input logic           reset,
    store_merge_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] data_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        is_word;
    logic        reject;
    logic        accept;

    // Reserved size 11 only reaches the word path when alignment checking is off.
    always_comb begin
        is_word = (bus.size == 2'b00) || (bus.size == 2'b11);
`ifdef STORE_MISALIGN_CHECK_EN
        reject = (bus.size == 2'b11) ||
                 ((bus.size == 2'b01) && bus.addr[0]) ||
                 ((bus.size == 2'b00) && (bus.addr[1:0] != 2'b00));
`else
        reject = 1'b0;
`endif
        accept = (state_q == IDLE) && bus.start && !reject;
    end

    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic [15:0] data);
        logic [31:0] m;
        m = word;
        if (size == 2'b01) begin
            if (lane[1]) m[31:16] = data;
            else         m[15:0]  = data;
        end else begin
            case (lane)
                2'd0:    m[7:0]   = data[7:0];
                2'd1:    m[15:8]  = data[7:0];
                2'd2:    m[23:16] = data[7:0];
                default: m[31:24] = data[7:0];
            endcase
        end
        return m;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (reject)       state_d = ERR;
                    else if (is_word) state_d = WRITE;
                    else              state_d = READ;
                end
            end
            READ:    state_d = WAIT;
            WAIT:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            data_q      <= 16'h0000;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mem_addr_q <= {bus.addr[31:2], 2'b00};
                size_q     <= bus.size;
                lane_q     <= bus.addr[1:0];
                data_q     <= bus.wdata[15:0];
                if (is_word) mem_wdata_q <= bus.wdata;
            end
            // Read data is valid during WAIT; the merged word doubles as the captured read word.
            if (state_q == WAIT) begin
                mem_wdata_q <= merge_lane(bus.mem_rdata, size_q, lane_q, data_q);
            end
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wr    = (state_q == WRITE);
    assign bus.done      = (state_q == WRITE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.fsm_state = state_q;
`ifdef STORE_MISALIGN_CHECK_EN
    assign bus.misalign  = (state_q == ERR);
`else
    assign bus.misalign  = 1'b0;
`endif
endmodule

// File: doc/store_merge_ctrl.md
STORE_MERGE_CTRL -- requirements
Module: store_merge_ctrl

Interface
REQ-001 Parameters: none; data and address widths SHALL be fixed at 32 bits.
REQ-002 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  store request, sampled only in IDLE.
REQ-005 size  in  2  store size: 00 word (SW), 01 halfword (SH), 10 byte (SB), 11 reserved.
REQ-006 addr  in  32  byte address of the store.
REQ-007 wdata  in  32  register data; SB uses [7:0], SH uses [15:0].
REQ-008 mem_rdata  in  32  memory read word, valid one cycle after mem_addr is presented with mem_wr=0.
REQ-009 mem_addr  out  32  word-aligned memory address, {addr[31:2],2'b00}.
REQ-010 mem_wdata  out  32  merged word to write.
REQ-011 mem_wr  out  1  memory write strobe, one cycle per store.
REQ-012 busy  out  1  high whenever state != IDLE.
REQ-013 done  out  1  one-cycle pulse on the completing write cycle.
REQ-014 misalign  out  1  one-cycle pulse on a rejected store.

Function
REQ-015 On start in IDLE, addr, size and wdata SHALL be registered; later input changes SHALL NOT affect the operation.
REQ-016 Start while busy SHALL be ignored and SHALL NOT be queued.
REQ-017 States: IDLE, READ, WAIT, WRITE, ERR.
REQ-018 Transitions: IDLE->WRITE (word), IDLE->READ (byte/half), IDLE->ERR (rejected), READ->WAIT->WRITE, WRITE->IDLE, ERR->IDLE.
REQ-019 READ drives mem_addr with mem_wr=0; WAIT captures mem_rdata into an internal word register at its closing edge.
REQ-020 WRITE SHALL assert mem_wr=1 and done=1 for exactly one cycle, with mem_addr and mem_wdata valid.
REQ-021 Latency from the start edge to the WRITE cycle: word 1 cycle; byte/half 3 cycles.
REQ-022 Lane mapping is little-endian: byte lane k = bits [8k+7:8k].
REQ-023 Byte lane = addr[1:0]; halfword lane = addr[1] (bits [15:0] or [31:16]).
REQ-024 mem_wdata for SB/SH = read word with only the selected lane replaced by the low bits of wdata; all other bits unchanged.
REQ-025 mem_wdata for SW = wdata unmodified, with no memory read.
REQ-026 ERR lasts one cycle: misalign=1, mem_wr=0, done=0, memory untouched.
REQ-027 mem_addr and mem_wdata SHALL hold their last values while IDLE.
REQ-028 Back-to-back: a start in the first IDLE cycle after WRITE SHALL be accepted.

Reset
REQ-029 Reset SHALL force IDLE with busy=0, done=0, mem_wr=0, misalign=0, mem_addr=0, mem_wdata=0 after the next edge.
REQ-030 Reset SHALL take priority over start and over any state.
REQ-031 Reset asserted in READ/WAIT/WRITE SHALL abort the operation; no mem_wr SHALL occur in the cycle after reset is sampled.

Configuration
REQ-032 Macro STORE_MISALIGN_CHECK_EN defined: SH with addr[0]=1, SW with addr[1:0]!=0, and size=11 SHALL go to ERR.
REQ-033 Macro undefined: misalign SHALL be tied 0; SH ignores addr[0]; SW ignores addr[1:0]; size=11 SHALL behave as SW.

Verification
REQ-034 SW addr=0x100 wdata=0xDEADBEEF -> next cycle mem_wr=1, done=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, with no read cycle.
REQ-035 SB addr=0x203 wdata=0x000000AB, mem word=0x11223344 -> WRITE 3 cycles after start, mem_wdata=0xAB223344, mem_addr=0x200.
REQ-036 SH addr=0x302 wdata=0x0000CAFE, mem word=0x11223344 -> mem_wdata=0xCAFE3344; start re-pulsed during WAIT is ignored.
REQ-037 Macro on, SH addr=0x301 -> misalign=1 for 1 cycle, mem_wr never asserted; macro off -> same stimulus writes the lower half.
REQ-038 SB start, then reset in WAIT -> IDLE, busy=0, mem_wr stays 0; a new SW immediately after reset completes normally.
